// File: rtl/fsm_reach_monitor_if.sv
// Signal bundle between an FSM under test (plus its stimulus source) and fsm_reach_monitor.
// master drives FSM state, outputs and run control; slave is the monitor.
interface fsm_reach_monitor_if #(
  parameter int CNT_W = 33,
  parameter int EVT_W = 16
);
  logic             start;
  logic [31:0]      S;
  logic             W;
  logic             Z;
  logic [31:0]      target;
  logic             busy;
  logic             done;
  logic             hit;
  logic             timeout;
  logic [CNT_W-1:0] cycles;
  logic [EVT_W-1:0] w_count;
  logic [EVT_W-1:0] z_count;
  logic             onehot_err;

  modport master (
    output start, S, W, Z, target,
    input  busy, done, hit, timeout, cycles, w_count, z_count, onehot_err
  );

  modport slave (
    input  start, S, W, Z, target,
    output busy, done, hit, timeout, cycles, w_count, z_count, onehot_err
  );
endinterface

// File: rtl/fsm_reach_monitor.sv
// Observer that counts cycles until a 32-bit FSM state reaches a target, with W/Z tallies.
// Optional one-hot checking of S is enabled by defining FSM_REACH_ONEHOT_CHECK_EN.
module fsm_reach_monitor #(
  parameter int              CNT_W   = 33,
  parameter longint unsigned TIMEOUT = 1000000,
  parameter int              EVT_W   = 16
) (
  input logic              CLK,
  input logic              Clear,
  fsm_reach_monitor_if.slave mon
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HIT  = 2'd2,
    TOUT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 64'd1);
  localparam logic [CNT_W-1:0] TMO_FULL = CNT_W'(TIMEOUT);

  state_t           state_q,  state_d;
  logic [31:0]      tgt_q,    tgt_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [EVT_W-1:0] w_cnt_q,  w_cnt_d;
  logic [EVT_W-1:0] z_cnt_q,  z_cnt_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic             hit_q,    hit_d;
  logic             tout_q,   tout_d;

`ifdef FSM_REACH_ONEHOT_CHECK_EN
  logic oh_err_q, oh_err_d;
  logic s_not_onehot;

  assign s_not_onehot = ($countones(mon.S) != 1);
`endif

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    cycles_d = cycles_q;
    w_cnt_d  = w_cnt_q;
    z_cnt_d  = z_cnt_q;
`ifdef FSM_REACH_ONEHOT_CHECK_EN
    oh_err_d = oh_err_q;
`endif

    unique case (state_q)
      RUN: begin
        // Match beats timeout; the matching cycle's W/Z are not part of the run.
        if (mon.S == tgt_q) begin
          state_d = HIT;
        end else begin
          if (mon.W && (w_cnt_q != '1)) w_cnt_d = w_cnt_q + EVT_W'(1);
          if (mon.Z && (z_cnt_q != '1)) z_cnt_d = z_cnt_q + EVT_W'(1);
          if (cycles_q == TMO_LAST) begin
            state_d  = TOUT;
            cycles_d = TMO_FULL;
          end else begin
            cycles_d = cycles_q + CNT_W'(1);
          end
        end
`ifdef FSM_REACH_ONEHOT_CHECK_EN
        if (s_not_onehot) oh_err_d = 1'b1;
`endif
      end

      default: begin
        // IDLE, HIT and TOUT all (re)start identically on a start pulse.
        if (mon.start) begin
          state_d  = RUN;
          tgt_d    = mon.target;
          cycles_d = '0;
          w_cnt_d  = '0;
          z_cnt_d  = '0;
`ifdef FSM_REACH_ONEHOT_CHECK_EN
          oh_err_d = 1'b0;
`endif
        end
      end
    endcase

    busy_d = (state_d == RUN);
    hit_d  = (state_d == HIT);
    tout_d = (state_d == TOUT);
    done_d = (state_d == HIT) || (state_d == TOUT);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (Clear) begin
      state_q  <= IDLE;
      tgt_q    <= '0;
      cycles_q <= '0;
      w_cnt_q  <= '0;
      z_cnt_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hit_q    <= 1'b0;
      tout_q   <= 1'b0;
`ifdef FSM_REACH_ONEHOT_CHECK_EN
      oh_err_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      cycles_q <= cycles_d;
      w_cnt_q  <= w_cnt_d;
      z_cnt_q  <= z_cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hit_q    <= hit_d;
      tout_q   <= tout_d;
`ifdef FSM_REACH_ONEHOT_CHECK_EN
      oh_err_q <= oh_err_d;
`endif
    end
  end

  assign mon.busy    = busy_q;
  assign mon.done    = done_q;
  assign mon.hit     = hit_q;
  assign mon.timeout = tout_q;
  assign mon.cycles  = cycles_q;
  assign mon.w_count = w_cnt_q;
  assign mon.z_count = z_cnt_q;
`ifdef FSM_REACH_ONEHOT_CHECK_EN
  assign mon.onehot_err = oh_err_q;
`else
  assign mon.onehot_err = 1'b0;
`endif

endmodule

// File: tb/tb_fsm_reach_monitor.sv
// Self-checking bench for fsm_reach_monitor: directed scenarios plus randomized runs
// checked against a sequence-level reference model.
module tb_fsm_reach_monitor;

  localparam int CNT_W = 33;
  localparam int TMO_A = 8;
  localparam int TMO_B = 100;
  localparam int EVT_A = 16;
  localparam int EVT_B = 4;
`ifdef FSM_REACH_ONEHOT_CHECK_EN
  localparam bit OH_EN = 1'b1;
`else
  localparam bit OH_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        Clear;
  logic        start;
  logic [31:0] S;
  logic        W;
  logic        Z;
  logic [31:0] target;

  always #5 CLK = ~CLK;

  fsm_reach_monitor_if #(.CNT_W(CNT_W), .EVT_W(EVT_A)) if_a ();
  fsm_reach_monitor_if #(.CNT_W(CNT_W), .EVT_W(EVT_B)) if_b ();

  assign if_a.start  = start;
  assign if_a.S      = S;
  assign if_a.W      = W;
  assign if_a.Z      = Z;
  assign if_a.target = target;
  assign if_b.start  = start;
  assign if_b.S      = S;
  assign if_b.W      = W;
  assign if_b.Z      = Z;
  assign if_b.target = target;

  fsm_reach_monitor #(.CNT_W(CNT_W), .TIMEOUT(TMO_A), .EVT_W(EVT_A)) u_dut_a (
    .CLK  (CLK),
    .Clear(Clear),
    .mon  (if_a)
  );

  fsm_reach_monitor #(.CNT_W(CNT_W), .TIMEOUT(TMO_B), .EVT_W(EVT_B)) u_dut_b (
    .CLK  (CLK),
    .Clear(Clear),
    .mon  (if_b)
  );

  // flags = {busy, done, hit, timeout, onehot_err}
  typedef struct packed {
    logic [4:0]       flags;
    logic [CNT_W-1:0] cyc;
    logic [15:0]      wc;
    logic [15:0]      zc;
  } obs_t;

  int errors = 0;
  int checks = 0;

  logic [31:0] s_seq[$];
  bit          w_seq[$];
  bit          z_seq[$];

  function automatic obs_t mk(input logic [4:0] flags, input int cyc, input int wc, input int zc);
    obs_t r;
    r.flags = flags;
    r.cyc   = CNT_W'(cyc);
    r.wc    = 16'(wc);
    r.zc    = 16'(zc);
    return r;
  endfunction

  function automatic obs_t read_dut(input bit sel_b);
    obs_t r;
    if (!sel_b) begin
      r.flags = {if_a.busy, if_a.done, if_a.hit, if_a.timeout, if_a.onehot_err};
      r.cyc   = if_a.cycles;
      r.wc    = if_a.w_count;
      r.zc    = if_a.z_count;
    end else begin
      r.flags = {if_b.busy, if_b.done, if_b.hit, if_b.timeout, if_b.onehot_err};
      r.cyc   = if_b.cycles;
      r.wc    = 16'(if_b.w_count);
      r.zc    = 16'(if_b.z_count);
    end
    return r;
  endfunction

  // Outcome of a whole run derived from the recorded RUN-cycle sequence:
  // first index k with S==target decides HIT (k < timeout) or TOUT.
  function automatic obs_t model(input logic [31:0] tgt, input int tmo, input int evt_max);
    obs_t r;
    int   k = -1;
    int   n_cnt;
    int   n_seen;
    int   wsum = 0;
    int   zsum = 0;
    bit   oh = 1'b0;
    foreach (s_seq[i]) if (k < 0 && s_seq[i] == tgt) k = i;
    if (k >= 0 && k < tmo) begin
      r.flags = 5'b01100;
      r.cyc   = CNT_W'(k);
      n_cnt   = k;
      n_seen  = k + 1;
    end else begin
      r.flags = 5'b01010;
      r.cyc   = CNT_W'(tmo);
      n_cnt   = tmo;
      n_seen  = tmo;
    end
    for (int i = 0; i < n_cnt; i++) begin
      wsum += int'(w_seq[i]);
      zsum += int'(z_seq[i]);
    end
    for (int i = 0; i < n_seen; i++) if ($countones(s_seq[i]) != 1) oh = 1'b1;
    r.wc       = 16'((wsum > evt_max) ? evt_max : wsum);
    r.zc       = 16'((zsum > evt_max) ? evt_max : zsum);
    r.flags[0] = oh & OH_EN;
    return r;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_clear();
    Clear = 1'b1;
    start = 1'b0;
    step();
    Clear = 1'b0;
  endtask

  task automatic pulse_start(input logic [31:0] tgt);
    start  = 1'b1;
    target = tgt;
    step();
    start  = 1'b0;
  endtask

  task automatic test_reset();
    obs_t got, exp;
    Clear  = 1'b1;
    start  = 1'b1;
    target = 32'h0000_0001;
    S      = 32'h0000_0001;
    W      = 1'b1;
    Z      = 1'b1;
    step();
    step();
    exp = mk(5'b00000, 0, 0, 0);
    for (int d = 0; d < 2; d++) begin
      got = read_dut(d[0]);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_dut%0d: got f=%b c=%0d w=%0d z=%0d exp f=%b c=%0d w=%0d z=%0d",
                 d, got.flags, got.cyc, got.wc, got.zc, exp.flags, exp.cyc, exp.wc, exp.zc);
      end
    end
    Clear = 1'b0;
    start = 1'b0;
    repeat (3) step();
    got = read_dut(1'b0);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_idle_hold: got f=%b c=%0d w=%0d z=%0d exp f=%b c=%0d w=%0d z=%0d",
               got.flags, got.cyc, got.wc, got.zc, exp.flags, exp.cyc, exp.wc, exp.zc);
    end
  endtask

  task automatic test_hit_latency();
    obs_t got, exp;
    apply_clear();
    S = 32'h1;
    W = 1'b0;
    Z = 1'b0;
    pulse_start(32'h0000_0080);
    got = read_dut(1'b0);
    exp = mk(5'b10000, 0, 0, 0);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL hit_started: got f=%b c=%0d w=%0d z=%0d exp f=%b c=%0d w=%0d z=%0d",
               got.flags, got.cyc, got.wc, got.zc, exp.flags, exp.cyc, exp.wc, exp.zc);
    end
    target = 32'h0000_0001;
    repeat (5) step();
    S = 32'h80;
    step();
    exp = mk(5'b01100, 5, 0, 0);
    for (int i = 0; i < 11; i++) begin
      got = read_dut(1'b0);
      if (i == 0 || i == 10) begin
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL hit_cycles5_t%0d: got f=%b c=%0d w=%0d z=%0d exp f=%b c=%0d w=%0d z=%0d",
                   i, got.flags, got.cyc, got.wc, got.zc, exp.flags, exp.cyc, exp.wc, exp.zc);
        end
      end
      S = 32'h1 << $urandom_range(0, 31);
      W = 1'($urandom);
      Z = 1'($urandom);
      step();
    end
  endtask

  task automatic test_timeout();
    obs_t got, exp;
    apply_clear();
    S = 32'h1;
    W = 1'b0;
    Z = 1'b0;
    pulse_start(32'hFFFF_FFFF);
    for (int k = 0; k < TMO_A; k++) begin
      S = 32'h1 << k;
      W = (k % 2 == 0);
      step();
      if (k == 3) begin
        got = read_dut(1'b0);
        exp = mk(5'b10000, 4, 2, 0);
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL tout_midrun: got f=%b c=%0d w=%0d z=%0d exp f=%b c=%0d w=%0d z=%0d",
                   got.flags, got.cyc, got.wc, got.zc, exp.flags, exp.cyc, exp.wc, exp.zc);
        end
      end
    end
    got = read_dut(1'b0);
    exp = mk(5'b01010, 8, 4, 0);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL tout_final: got f=%b c=%0d w=%0d z=%0d exp f=%b c=%0d w=%0d z=%0d",
               got.flags, got.cyc, got.wc, got.zc, exp.flags, exp.cyc, exp.wc, exp.zc);
    end
  endtask

  task automatic test_hit_on_last();
    obs_t got, exp;
    apply_clear();
    S = 32'h1;
    W = 1'b1;
    Z = 1'b1;
    pulse_start(32'h0000_0040);
    for (int k = 0; k < TMO_A; k++) begin
      S = (k == TMO_A - 1) ? 32'h40 : 32'h1;
      step();
    end
    got = read_dut(1'b0);
    exp = mk(5'b01100, 7, 7, 7);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL hit_beats_tout: got f=%b c=%0d w=%0d z=%0d exp f=%b c=%0d w=%0d z=%0d",
               got.flags, got.cyc, got.wc, got.zc, exp.flags, exp.cyc, exp.wc, exp.zc);
    end
  endtask

  task automatic test_saturate_clear();
    obs_t got, exp;
    apply_clear();
    S = 32'h1;
    W = 1'b0;
    Z = 1'b1;
    pulse_start(32'h0000_0000);
    repeat (20) step();
    got = read_dut(1'b1);
    exp = mk(5'b10000, 20, 0, 15);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL z_saturate: got f=%b c=%0d w=%0d z=%0d exp f=%b c=%0d w=%0d z=%0d",
               got.flags, got.cyc, got.wc, got.zc, exp.flags, exp.cyc, exp.wc, exp.zc);
    end
    Clear = 1'b1;
    start = 1'b1;
    step();
    Clear = 1'b0;
    start = 1'b0;
    got = read_dut(1'b1);
    exp = mk(5'b00000, 0, 0, 0);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL clear_midrun: got f=%b c=%0d w=%0d z=%0d exp f=%b c=%0d w=%0d z=%0d",
               got.flags, got.cyc, got.wc, got.zc, exp.flags, exp.cyc, exp.wc, exp.zc);
    end
    Z = 1'b0;
    pulse_start(32'h0000_0002);
    got = read_dut(1'b1);
    exp = mk(5'b10000, 0, 0, 0);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL restart_zero: got f=%b c=%0d w=%0d z=%0d exp f=%b c=%0d w=%0d z=%0d",
               got.flags, got.cyc, got.wc, got.zc, exp.flags, exp.cyc, exp.wc, exp.zc);
    end
    S = 32'h2;
    Z = 1'b1;
    step();
    got = read_dut(1'b1);
    exp = mk(5'b01100, 0, 0, 0);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL first_cycle_hit: got f=%b c=%0d w=%0d z=%0d exp f=%b c=%0d w=%0d z=%0d",
               got.flags, got.cyc, got.wc, got.zc, exp.flags, exp.cyc, exp.wc, exp.zc);
    end
  endtask

  task automatic test_onehot();
    obs_t got, exp;
    apply_clear();
    S = 32'h1;
    W = 1'b0;
    Z = 1'b0;
    pulse_start(32'h8000_0000);
    for (int k = 0; k < TMO_A; k++) begin
      S = (k == 0) ? 32'h3 : (32'h1 << k);
      step();
      if (k == 4) begin
        got = read_dut(1'b0);
        exp = mk({4'b1000, OH_EN}, 5, 0, 0);
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL onehot_set: got f=%b c=%0d w=%0d z=%0d exp f=%b c=%0d w=%0d z=%0d",
                   got.flags, got.cyc, got.wc, got.zc, exp.flags, exp.cyc, exp.wc, exp.zc);
        end
      end
    end
    got = read_dut(1'b0);
    exp = mk({4'b0101, OH_EN}, 8, 0, 0);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL onehot_sticky: got f=%b c=%0d w=%0d z=%0d exp f=%b c=%0d w=%0d z=%0d",
               got.flags, got.cyc, got.wc, got.zc, exp.flags, exp.cyc, exp.wc, exp.zc);
    end
    S = 32'h1;
    pulse_start(32'h0000_0010);
    got = read_dut(1'b0);
    exp = mk(5'b10000, 0, 0, 0);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL onehot_cleared: got f=%b c=%0d w=%0d z=%0d exp f=%b c=%0d w=%0d z=%0d",
               got.flags, got.cyc, got.wc, got.zc, exp.flags, exp.cyc, exp.wc, exp.zc);
    end
  endtask

  task automatic test_random(input int runs);
    obs_t        got, exp;
    logic [31:0] tgt;
    bit          sel_b;
    bit          allow_match;
    int          tmo;
    int          evt_max;
    for (int r = 0; r < runs; r++) begin
      sel_b       = r[0];
      tmo         = sel_b ? TMO_B : TMO_A;
      evt_max     = sel_b ? (1 << EVT_B) - 1 : (1 << EVT_A) - 1;
      allow_match = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       tgt = 32'h0;
        1:       tgt = $urandom;
        default: tgt = 32'h1 << $urandom_range(0, 31);
      endcase
      s_seq.delete();
      w_seq.delete();
      z_seq.delete();
      for (int k = 0; k < tmo + 2; k++) begin
        if (allow_match && $urandom_range(0, tmo - 1) == 0) s_seq.push_back(tgt);
        else if ($urandom_range(0, 19) == 0)                s_seq.push_back($urandom);
        else                                                s_seq.push_back(32'h1 << $urandom_range(0, 31));
        w_seq.push_back($urandom_range(0, 3) != 0);
        z_seq.push_back($urandom_range(0, 2) == 0);
      end
      apply_clear();
      S = 32'h0;
      W = 1'b0;
      Z = 1'b0;
      pulse_start(tgt);
      foreach (s_seq[k]) begin
        S      = s_seq[k];
        W      = w_seq[k];
        Z      = z_seq[k];
        target = $urandom;
        step();
      end
      got = read_dut(sel_b);
      exp = model(tgt, tmo, evt_max);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random_run%0d_dut%0d: got f=%b c=%0d w=%0d z=%0d exp f=%b c=%0d w=%0d z=%0d",
                 r, sel_b, got.flags, got.cyc, got.wc, got.zc, exp.flags, exp.cyc, exp.wc, exp.zc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hit_latency();
    test_timeout();
    test_hit_on_last();
    test_saturate_clear();
    test_onehot();
    test_random(40);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
